// File: rtl/frame_update_scheduler.sv
// Per-frame update sequencer: on a vSync falling edge it strobes each enabled
// pixel-layer client in index order and waits for its done, with a per-client timeout.
module frame_update_scheduler #(
  parameter int NUM_CLIENTS    = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int IDX_W          = 2
) (
  input  logic                   ClkPort,
  input  logic                   Reset,
  input  logic                   vSync,
  input  logic                   enable,
  input  logic [3:0]             frame_div,
  input  logic [NUM_CLIENTS-1:0] client_en,
  input  logic [NUM_CLIENTS-1:0] upd_done,
  input  logic                   clr_status,
  output logic [NUM_CLIENTS-1:0] upd_start,
  output logic                   busy,
  output logic [IDX_W-1:0]       cur_client,
  output logic [15:0]            frame_count,
  output logic                   overrun,
  output logic                   timeout_err,
  output logic [IDX_W-1:0]       timeout_client
);

  // state  | meaning
  // IDLE   | waiting for a launch frame
  // SELECT | skip disabled clients, or finish once the index runs past the last client
  // START  | one-cycle start strobe to the current client
  // WAIT   | wait for the current client's done or its timeout
  // FINISH | sequence complete, return to IDLE

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W:0]   IDX_END  = (IDX_W+1)'(NUM_CLIENTS);

  state_t state_q, state_d;

  logic                   vsync_d;
  logic                   frame_start;
  logic [3:0]             div_cnt;
  logic                   div_hit;
  logic                   launch;

  // one extra index bit so the index can step past the last client
  logic [IDX_W:0]         idx_q;
  logic                   idx_valid;
  logic [NUM_CLIENTS-1:0] sel_oh;
  logic                   en_sel;
  logic                   done_sel;

  logic [TMO_W-1:0]       tmo_cnt;
  logic                   tmo_zero;

  logic                   idx_clr;
  logic                   idx_inc;
  logic                   tmo_load;
  logic                   tmo_dec;
  logic                   tmo_fire;

  assign frame_start = vsync_d & ~vSync;
  assign div_hit     = (div_cnt == frame_div);
  assign launch      = frame_start & div_hit;
  assign idx_valid   = (idx_q < IDX_END);
  assign tmo_zero    = (tmo_cnt == '0);

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      sel_oh[i] = (idx_q == (IDX_W+1)'(i));
    end
  end

  assign en_sel   = |(client_en & sel_oh);
  assign done_sel = |(upd_done & sel_oh);

  // frame detection, frame counter and launch divider run independently of the FSM
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      vsync_d     <= 1'b1;
      frame_count <= 16'd0;
      div_cnt     <= 4'd0;
    end else begin
      vsync_d <= vSync;
      if (frame_start) begin
        frame_count <= frame_count + 16'd1;
        div_cnt     <= div_hit ? 4'd0 : div_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_clr  = 1'b0;
    idx_inc  = 1'b0;
    tmo_load = 1'b0;
    tmo_dec  = 1'b0;
    tmo_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (launch && enable) begin
          idx_clr = 1'b1;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (!idx_valid) begin
          state_d = S_FINISH;
        end else if (!en_sel) begin
          idx_inc = 1'b1;
        end else begin
          state_d = S_START;
        end
      end
      S_START: begin
        tmo_load = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // done is checked first so a done on the last allowed cycle is not an error
        if (done_sel) begin
          idx_inc = 1'b1;
          state_d = S_SELECT;
        end else if (tmo_zero) begin
          tmo_fire = 1'b1;
          idx_inc  = 1'b1;
          state_d  = S_SELECT;
        end else begin
          tmo_dec = 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    upd_start = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      upd_start[i] = (state_q == S_START) && (idx_q == (IDX_W+1)'(i));
    end
    busy       = (state_q != S_IDLE);
    cur_client = ((state_q == S_START) || (state_q == S_WAIT)) ? idx_q[IDX_W-1:0] : '0;
  end

  // the timeout timer counts down from TIMEOUT_CYCLES-1, so WAIT lasts at most TIMEOUT_CYCLES cycles
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      idx_q   <= '0;
      tmo_cnt <= '0;
    end else begin
      if (idx_clr) begin
        idx_q <= '0;
      end else if (idx_inc) begin
        idx_q <= idx_q + 1'b1;
      end
      if (tmo_load) begin
        tmo_cnt <= TMO_LOAD;
      end else if (tmo_dec) begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      overrun        <= 1'b0;
      timeout_err    <= 1'b0;
      timeout_client <= '0;
    end else begin
      if (frame_start && (state_q != S_IDLE)) begin
        overrun <= 1'b1;
      end else if (clr_status) begin
        overrun <= 1'b0;
      end
      if (tmo_fire) begin
        timeout_err    <= 1'b1;
        timeout_client <= idx_q[IDX_W-1:0];
      end else if (clr_status) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Scoreboard bench for frame_update_scheduler: expected start strobes are queued
// by the stimulus and checked by a separate monitor as the DUT issues them.
module tb_frame_update_scheduler;

  localparam int NC = 4;
  localparam int IW = 2;

  typedef struct packed {
    logic [NC-1:0] start;
    logic [IW-1:0] cli;
  } exp_t;

  logic          ClkPort = 1'b0;
  logic          Reset = 1'b1;
  logic          vSync = 1'b1;
  logic          enable = 1'b0;
  logic [3:0]    frame_div = 4'd0;
  logic [NC-1:0] client_en = '0;
  logic [NC-1:0] upd_done = '0;
  logic          clr_status = 1'b0;
  logic [NC-1:0] upd_start;
  logic          busy;
  logic [IW-1:0] cur_client;
  logic [15:0]   frame_count;
  logic          overrun;
  logic          timeout_err;
  logic [IW-1:0] timeout_client;

  int   total = 0;
  int   bad = 0;
  int   mon_total = 0;
  int   mon_bad = 0;
  int   cyc = 0;
  int   busy_total = 0;
  int   b0 = 0;
  int   start_time[NC];
  int   rdelay[NC];
  int   rcnt[NC];
  exp_t exp_q[$];

  frame_update_scheduler #(
    .NUM_CLIENTS(NC),
    .TIMEOUT_CYCLES(8),
    .IDX_W(IW)
  ) dut (
    .ClkPort(ClkPort),
    .Reset(Reset),
    .vSync(vSync),
    .enable(enable),
    .frame_div(frame_div),
    .client_en(client_en),
    .upd_done(upd_done),
    .clr_status(clr_status),
    .upd_start(upd_start),
    .busy(busy),
    .cur_client(cur_client),
    .frame_count(frame_count),
    .overrun(overrun),
    .timeout_err(timeout_err),
    .timeout_client(timeout_client)
  );

  always #5 ClkPort = ~ClkPort;

  // monitor: pops the scoreboard whenever a start strobe is presented
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge ClkPort);
      cyc++;
      if (busy) busy_total++;
      if (!Reset && upd_start != '0) begin
        mon_total++;
        if (exp_q.size() == 0) begin
          mon_bad++;
          $display("FAIL sb_unexpected: got start=%b cur=%0d want no start", upd_start, cur_client);
        end else begin
          e = exp_q.pop_front();
          if (upd_start !== e.start || cur_client !== e.cli) begin
            mon_bad++;
            $display("FAIL sb_start: got start=%b cur=%0d want start=%b cur=%0d",
                     upd_start, cur_client, e.start, e.cli);
          end
        end
        for (int i = 0; i < NC; i++) begin
          if (upd_start[i]) start_time[i] = cyc;
        end
      end
    end
  end

  // client model: done pulses rdelay cycles after its start; rdelay 0 never answers
  initial begin : responder
    forever begin
      @(posedge ClkPort);
      #1;
      for (int i = 0; i < NC; i++) begin
        if (Reset) begin
          rcnt[i] = 0;
          upd_done[i] = 1'b0;
        end else if (upd_start[i]) begin
          rcnt[i] = rdelay[i];
          upd_done[i] = 1'b0;
        end else if (rcnt[i] > 0) begin
          rcnt[i]--;
          upd_done[i] = (rcnt[i] == 0);
        end else begin
          upd_done[i] = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input int c);
    exp_t e;
    e.start = 4'b0001 << c;
    e.cli   = IW'(c);
    exp_q.push_back(e);
  endtask

  task automatic start_frame();
    @(posedge ClkPort);
    #1 vSync = 1'b0;
    @(posedge ClkPort);
    @(posedge ClkPort);
    #1 vSync = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge ClkPort);
    while (busy && n < 300) begin
      @(negedge ClkPort);
      n++;
    end
    check("idle_wait", 32'(busy), 32'd0);
    check("sb_drain", exp_q.size(), 0);
    @(posedge ClkPort);
    #1;
  endtask

  task automatic pulse_clr();
    @(posedge ClkPort);
    #1 clr_status = 1'b1;
    @(posedge ClkPort);
    #1 clr_status = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin
      rdelay[i] = 3;
      rcnt[i] = 0;
      start_time[i] = 0;
    end

    repeat (3) @(negedge ClkPort);
    check("reset_init", {upd_start, busy, cur_client, frame_count, overrun, timeout_err, timeout_client}, 0);
    Reset = 1'b0;
    repeat (2) @(posedge ClkPort);
    #1;

    // all four clients, done 3 cycles after each start
    enable = 1'b1;
    client_en = 4'b1111;
    for (int c = 0; c < NC; c++) push(c);
    b0 = busy_total;
    start_frame();
    wait_idle();
    check("busy_len_all", busy_total - b0, 22);
    check("frame_cnt_1", frame_count, 1);
    check("gap_0_1", start_time[1] - start_time[0], 5);

    // clients 1 and 3 disabled
    client_en = 4'b0101;
    push(0);
    push(2);
    b0 = busy_total;
    start_frame();
    wait_idle();
    check("busy_len_skip", busy_total - b0, 14);
    check("frame_cnt_2", frame_count, 2);

    // client 1 never answers
    client_en = 4'b1111;
    rdelay[1] = 0;
    for (int c = 0; c < NC; c++) push(c);
    b0 = busy_total;
    start_frame();
    wait_idle();
    check("busy_len_tmo", busy_total - b0, 27);
    check("gap_tmo_1_2", start_time[2] - start_time[1], 10);
    check("tmo_err_set", 32'(timeout_err), 1);
    check("tmo_client_1", 32'(timeout_client), 1);
    check("ovr_clear_0", 32'(overrun), 0);
    pulse_clr();
    check("tmo_err_clr", 32'(timeout_err), 0);
    check("tmo_client_hold", 32'(timeout_client), 1);
    rdelay[1] = 3;

    // client 0 holds off while another frame start arrives
    rdelay[0] = 0;
    for (int c = 0; c < NC; c++) push(c);
    start_frame();
    start_frame();
    wait_idle();
    check("overrun_set", 32'(overrun), 1);
    check("frame_cnt_ovr", frame_count, 5);
    check("tmo_client_0", 32'(timeout_client), 0);
    pulse_clr();
    check("overrun_clr", 32'(overrun), 0);
    check("tmo_err_clr2", 32'(timeout_err), 0);
    rdelay[0] = 3;

    // update every third frame
    frame_div = 4'd2;
    b0 = busy_total;
    for (int f = 1; f <= 6; f++) begin
      if (f == 3 || f == 6) begin
        for (int c = 0; c < NC; c++) push(c);
      end
      start_frame();
      repeat (30) @(posedge ClkPort);
      #1;
    end
    wait_idle();
    check("frame_cnt_div", frame_count, 11);
    check("busy_len_div", busy_total - b0, 44);
    frame_div = 4'd0;

    // disabled: frames counted, nothing launched
    enable = 1'b0;
    b0 = busy_total;
    start_frame();
    repeat (5) @(posedge ClkPort);
    start_frame();
    wait_idle();
    check("busy_len_dis", busy_total - b0, 0);
    check("frame_cnt_dis", frame_count, 13);

    // reset while client 1 is being waited on
    enable = 1'b1;
    rdelay[1] = 0;
    push(0);
    push(1);
    start_frame();
    begin
      int n;
      n = 0;
      @(negedge ClkPort);
      while (!(busy && cur_client == 2'd1) && n < 100) begin
        @(negedge ClkPort);
        n++;
      end
      check("reach_client1", 32'(cur_client), 1);
    end
    @(posedge ClkPort);
    #2 Reset = 1'b1;
    #1;
    check("reset_async", {upd_start, busy, cur_client, frame_count, overrun, timeout_err, timeout_client}, 0);
    @(posedge ClkPort);
    #1;
    check("reset_hold", {upd_start, busy, cur_client, frame_count, overrun, timeout_err, timeout_client}, 0);
    check("sb_drain_rst", exp_q.size(), 0);
    @(negedge ClkPort);
    Reset = 1'b0;
    rdelay[1] = 3;
    repeat (2) @(posedge ClkPort);
    #1;
    for (int c = 0; c < NC; c++) push(c);
    b0 = busy_total;
    start_frame();
    wait_idle();
    check("frame_cnt_post_rst", frame_count, 1);
    check("busy_len_post_rst", busy_total - b0, 22);

    repeat (3) @(posedge ClkPort);
    total = total + mon_total;
    bad = bad + mon_bad;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
